// File: rtl/updown_counter.sv
// Up/down counter with parallel load, synchronous clear, wrap or saturate at the
// limits, a one-cycle wrap pulse and a sticky overflow flag. UPDOWN_COUNTER_FORMAL_EN adds embedded checks.
module updown_counter #(
   parameter int unsigned       WIDTH    = 4,
   parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
   parameter bit                SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic             at_max, at_min;

   assign at_max = (count_q == MAX_VAL);
   assign at_min = (count_q == ZERO);
   assign tc     = enable && ((up && at_max) || (!up && at_min));

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      ovf_d   = ovf_q;
      if (clear) begin
         count_d = ZERO;
         ovf_d   = 1'b0;
      end else if (load) begin
         count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end else if (enable) begin
         if (tc) begin
            // Boundary step: saturating mode leaves count where it is.
            ovf_d = 1'b1;
            if (!SATURATE) begin
               count_d = up ? ZERO : MAX_VAL;
               wrap_d  = 1'b1;
            end
         end else begin
            count_d = up ? (count_q + ONE) : (count_q - ONE);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= ZERO;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign ovf   = ovf_q;

`ifdef UPDOWN_COUNTER_FORMAL_EN
   logic             prev_valid_q;
   logic             prev_enable_q, prev_up_q, prev_load_q, prev_clear_q, prev_ovf_q;
   logic [WIDTH-1:0] prev_count_q;
   logic [WIDTH-1:0] step_exp;

   initial assume (!reset_n);

   always_comb begin
      step_exp = prev_count_q;
      if (prev_up_q) begin
         if (prev_count_q == MAX_VAL) step_exp = SATURATE ? MAX_VAL : ZERO;
         else                         step_exp = prev_count_q + ONE;
      end else begin
         if (prev_count_q == ZERO)    step_exp = SATURATE ? ZERO : MAX_VAL;
         else                         step_exp = prev_count_q - ONE;
      end
   end

   // prev_* hold the inputs and state seen at the previous edge, so at this
   // edge count_q is the result that edge produced.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_valid_q  <= 1'b0;
         prev_enable_q <= 1'b0;
         prev_up_q     <= 1'b0;
         prev_load_q   <= 1'b0;
         prev_clear_q  <= 1'b0;
         prev_ovf_q    <= 1'b0;
         prev_count_q  <= ZERO;
      end else begin
         assert (count_q <= MAX_VAL);
         assert (!wrap_q || !SATURATE);
         if (prev_valid_q) begin
            if (prev_enable_q && !prev_clear_q && !prev_load_q)
               assert (count_q == step_exp);
            if (prev_ovf_q && !prev_clear_q)
               assert (ovf_q);
         end
         prev_valid_q  <= 1'b1;
         prev_enable_q <= enable;
         prev_up_q     <= up;
         prev_load_q   <= load;
         prev_clear_q  <= clear;
         prev_ovf_q    <= ovf_q;
         prev_count_q  <= count_q;
      end
   end
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Bench: a wrapping (MAX_VAL=9) and a saturating (MAX_VAL=15) counter share stimulus
// and are checked against an integer reference model plus directed expectations.
module tb_updown_counter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable, up, load, clear;
   logic [3:0] load_val;
   logic [3:0] cnt_o [2];
   logic       tc_o [2];
   logic       wrap_o [2];
   logic       ovf_o [2];

   int checks   = 0;
   int failures = 0;

   int m_cnt [2];
   int m_wrap [2];
   int m_ovf [2];
   int m_max [2] = '{9, 15};
   int m_sat [2] = '{0, 1};

   always #5 clk = ~clk;

   updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .clear(clear), .count(cnt_o[0]), .tc(tc_o[0]),
      .wrap(wrap_o[0]), .ovf(ovf_o[0]));

   updown_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .clear(clear), .count(cnt_o[1]), .tc(tc_o[1]),
      .wrap(wrap_o[1]), .ovf(ovf_o[1]));

   task automatic drive(input logic en, input logic u, input logic ld,
                        input int lv, input logic clr);
      enable   = en;
      up       = u;
      load     = ld;
      load_val = 4'(lv);
      clear    = clr;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         m_wrap[i] = 0;
         if (clear) begin
            m_cnt[i] = 0; m_ovf[i] = 0;
         end else if (load) begin
            m_cnt[i] = (int'(load_val) > m_max[i]) ? m_max[i] : int'(load_val);
         end else if (enable) begin
            if (up && m_cnt[i] == m_max[i]) begin
               m_ovf[i] = 1;
               if (m_sat[i] == 0) begin m_cnt[i] = 0; m_wrap[i] = 1; end
            end else if (!up && m_cnt[i] == 0) begin
               m_ovf[i] = 1;
               if (m_sat[i] == 0) begin m_cnt[i] = m_max[i]; m_wrap[i] = 1; end
            end else begin
               m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
            end
         end
      end
   endtask

   task automatic check_state(input string tag);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (cnt_o[i] !== 4'(m_cnt[i]) || wrap_o[i] !== 1'(m_wrap[i]) || ovf_o[i] !== 1'(m_ovf[i])) begin
            failures++;
            $display("FAIL %s dut%0d: count/wrap/ovf got %0d/%b/%b expected %0d/%0d/%0d",
                     tag, i, cnt_o[i], wrap_o[i], ovf_o[i], m_cnt[i], m_wrap[i], m_ovf[i]);
         end
      end
   endtask

   // One clock: check combinational tc against the model, take the edge, check state.
   task automatic step(input string tag);
      int exp_tc;
      #1;
      for (int i = 0; i < 2; i++) begin
         exp_tc = (enable && ((up && m_cnt[i] == m_max[i]) || (!up && m_cnt[i] == 0))) ? 1 : 0;
         checks++;
         if (tc_o[i] !== 1'(exp_tc)) begin
            failures++;
            $display("FAIL %s tc dut%0d: got %b expected %0d", tag, i, tc_o[i], exp_tc);
         end
      end
      @(posedge clk);
      model_edge();
      #1;
      check_state(tag);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      model_reset();
      #12;
      check_state("reset");
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_wrap_up();
      int seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      drive(0, 0, 0, 0, 1);
      step("wrap_up_clear");
      for (int k = 0; k < 12; k++) begin
         drive(1, 1, 0, 0, 0);
         step("wrap_up_model");
         checks++;
         if (cnt_o[0] !== 4'(seq[k]) || wrap_o[0] !== (k == 9) || ovf_o[0] !== (k >= 9)) begin
            failures++;
            $display("FAIL wrap_up step %0d: count/wrap/ovf got %0d/%b/%b expected %0d/%b/%b",
                     k, cnt_o[0], wrap_o[0], ovf_o[0], seq[k], k == 9, k >= 9);
         end
      end
   endtask

   task automatic test_wrap_down();
      drive(0, 0, 0, 0, 1);
      step("wrap_down_clear");
      drive(1, 0, 0, 0, 0);
      #1;
      checks++;
      if (tc_o[0] !== 1'b1) begin
         failures++;
         $display("FAIL wrap_down tc: got %b expected 1", tc_o[0]);
      end
      step("wrap_down_model");
      checks++;
      if (cnt_o[0] !== 4'd9 || wrap_o[0] !== 1'b1) begin
         failures++;
         $display("FAIL wrap_down: count/wrap got %0d/%b expected 9/1", cnt_o[0], wrap_o[0]);
      end
      drive(0, 0, 0, 0, 0);
      step("wrap_down_hold");
      checks++;
      if (wrap_o[0] !== 1'b0 || cnt_o[0] !== 4'd9) begin
         failures++;
         $display("FAIL wrap_down pulse: count/wrap got %0d/%b expected 9/0", cnt_o[0], wrap_o[0]);
      end
   endtask

   task automatic test_saturate();
      drive(0, 0, 0, 0, 1);
      step("sat_clear");
      drive(0, 0, 1, 15, 0);
      step("sat_load");
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 0, 0, 0);
         step("sat_model");
         checks++;
         if (cnt_o[1] !== 4'd15 || wrap_o[1] !== 1'b0 || ovf_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL saturate step %0d: count/wrap/ovf got %0d/%b/%b expected 15/0/1",
                     k, cnt_o[1], wrap_o[1], ovf_o[1]);
         end
      end
   endtask

   task automatic test_load_clamp();
      drive(1, 1, 1, 12, 0);
      step("load_clamp_model");
      checks++;
      if (cnt_o[0] !== 4'd9 || cnt_o[1] !== 4'd12) begin
         failures++;
         $display("FAIL load_clamp: counts got %0d/%0d expected 9/12", cnt_o[0], cnt_o[1]);
      end
   endtask

   task automatic test_clear_load();
      drive(1, 0, 1, 0, 0);
      step("clr_ld_zero");
      drive(1, 0, 0, 0, 0);
      step("clr_ld_ovf");
      drive(0, 0, 1, 7, 1);
      step("clr_ld_model");
      checks++;
      if (cnt_o[0] !== 4'd0 || ovf_o[0] !== 1'b0 || ovf_o[1] !== 1'b0) begin
         failures++;
         $display("FAIL clear_load: count/ovf0/ovf1 got %0d/%b/%b expected 0/0/0",
                  cnt_o[0], ovf_o[0], ovf_o[1]);
      end
   endtask

   task automatic test_async_reset();
      drive(0, 0, 1, 5, 0);
      step("async_load5");
      drive(1, 1, 0, 0, 0);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (cnt_o[0] !== 4'd0 || cnt_o[1] !== 4'd0 || ovf_o[0] !== 1'b0 || wrap_o[0] !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: count0/count1/ovf/wrap got %0d/%0d/%b/%b expected 0/0/0/0",
                  cnt_o[0], cnt_o[1], ovf_o[0], wrap_o[0]);
      end
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      check_state("async_first_edge");
   endtask

   task automatic test_random();
      int r;
      for (int k = 0; k < 400; k++) begin
         r = int'($urandom_range(0, 99));
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'(r < 8), int'($urandom_range(0, 15)), 1'(r >= 96));
         step("random");
      end
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_wrap_down();
      test_saturate();
      test_load_clamp();
      test_clear_load();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
